// File: rtl/apb_txn_monitor.sv
// Passive monitor for the RTC peripheral bus: follows the setup/access handshake, records each
// completed transfer and flags protocol errors. Define MON_COUNTERS_EN to build the per-mode counters.
module apb_txn_monitor #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] ADDR_TIME  = 'h00,
  parameter logic [ADDR_W-1:0] ADDR_ALARM = 'h04,
  parameter logic [ADDR_W-1:0] ADDR_ADJ   = 'h08,
  parameter int                TIMEOUT    = 16,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              enable,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ready,
  input  logic              cnt_clr,
  output logic              txn_valid,
  output logic [2:0]        txn_mode,
  output logic [ADDR_W-1:0] txn_addr,
  output logic [DATA_W-1:0] txn_data,
  output logic              err_valid,
  output logic [2:0]        err_code,
  output logic              fail,
  output logic [CNT_W-1:0]  cnt_rd,
  output logic [CNT_W-1:0]  cnt_time,
  output logic [CNT_W-1:0]  cnt_alarm,
  output logic [CNT_W-1:0]  cnt_adj,
  output logic [CNT_W-1:0]  cnt_inv
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] MODE_NONE  = 3'b000;
  localparam logic [2:0] MODE_RD    = 3'b001;
  localparam logic [2:0] MODE_TIME  = 3'b010;
  localparam logic [2:0] MODE_ALARM = 3'b011;
  localparam logic [2:0] MODE_ADJ   = 3'b100;
  localparam logic [2:0] MODE_INV   = 3'b101;

  localparam logic [2:0] ERR_NONE     = 3'b000;
  localparam logic [2:0] ERR_NO_SETUP = 3'b001;
  localparam logic [2:0] ERR_DROP     = 3'b010;
  localparam logic [2:0] ERR_UNSTABLE = 3'b011;
  localparam logic [2:0] ERR_TIMEOUT  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              state;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [WAIT_W-1:0]   wait_cnt;

  logic                setup_phase;
  logic                access_phase;
  logic                stable;
  logic [WAIT_W-1:0]   wait_next;
  logic                timeout_hit;
  logic [2:0]          cur_mode;
  logic [DATA_W-1:0]   cur_data;

  // SETUP is the state in which the first access cycle is observed, so both SETUP and ACCESS
  // judge the live bus against the fields latched during the setup phase.
  always_comb begin
    setup_phase  = sel && !enable;
    access_phase = sel && enable;
    stable       = (write == lat_write) && (addr == lat_addr) && (wdata == lat_wdata);
    wait_next    = wait_cnt + 1'b1;
    timeout_hit  = (wait_next == WAIT_W'(TIMEOUT));
    cur_data     = lat_write ? lat_wdata : rdata;
    cur_mode     = MODE_RD;
    if (lat_write) begin
      if (lat_addr == ADDR_TIME) begin
        cur_mode = MODE_TIME;
      end else if (lat_addr == ADDR_ALARM) begin
        cur_mode = MODE_ALARM;
      end else if (lat_addr == ADDR_ADJ) begin
        cur_mode = MODE_ADJ;
      end else begin
        cur_mode = MODE_INV;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      txn_valid <= 1'b0;
      txn_mode  <= MODE_NONE;
      txn_addr  <= '0;
      txn_data  <= '0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      fail      <= 1'b0;
    end else begin
      txn_valid <= 1'b0;
      err_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (setup_phase) begin
            state     <= S_SETUP;
            lat_write <= write;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            wait_cnt  <= '0;
          end else if (access_phase) begin
            err_valid <= 1'b1;
            err_code  <= ERR_NO_SETUP;
            fail      <= 1'b1;
          end
        end
        S_SETUP, S_ACCESS: begin
          if (!access_phase && state == S_SETUP) begin
            state     <= S_IDLE;
            err_valid <= 1'b1;
            err_code  <= ERR_DROP;
            fail      <= 1'b1;
          end else if (!access_phase || !stable) begin
            // A corrupted access is reported even if the slave says ready in the same cycle.
            state     <= S_IDLE;
            err_valid <= 1'b1;
            err_code  <= ERR_UNSTABLE;
            fail      <= 1'b1;
          end else if (ready) begin
            state     <= S_IDLE;
            txn_valid <= 1'b1;
            txn_mode  <= cur_mode;
            txn_addr  <= lat_addr;
            txn_data  <= cur_data;
          end else if (timeout_hit) begin
            state     <= S_IDLE;
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            fail      <= 1'b1;
          end else begin
            state    <= S_ACCESS;
            wait_cnt <= wait_next;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MON_COUNTERS_EN
  logic [CNT_W-1:0] cnt_q [5];

  // Counters follow the published record, so they lag txn_valid by one cycle; clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (cnt_clr) begin
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (txn_valid) begin
      case (txn_mode)
        MODE_RD:    if (cnt_q[0] != '1) cnt_q[0] <= cnt_q[0] + 1'b1;
        MODE_TIME:  if (cnt_q[1] != '1) cnt_q[1] <= cnt_q[1] + 1'b1;
        MODE_ALARM: if (cnt_q[2] != '1) cnt_q[2] <= cnt_q[2] + 1'b1;
        MODE_ADJ:   if (cnt_q[3] != '1) cnt_q[3] <= cnt_q[3] + 1'b1;
        MODE_INV:   if (cnt_q[4] != '1) cnt_q[4] <= cnt_q[4] + 1'b1;
        default: ;
      endcase
    end
  end

  assign cnt_rd    = cnt_q[0];
  assign cnt_time  = cnt_q[1];
  assign cnt_alarm = cnt_q[2];
  assign cnt_adj   = cnt_q[3];
  assign cnt_inv   = cnt_q[4];
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign cnt_rd         = '0;
  assign cnt_time       = '0;
  assign cnt_alarm      = '0;
  assign cnt_adj        = '0;
  assign cnt_inv        = '0;
`endif

endmodule
